// File: rtl/scalar_mult_ctrl.sv
// scalar_mult_ctrl
// Sequencer for right-to-left binary scalar multiplication R = k*P.
// Walks the scalar one key bit at a time, starting from bit 0.
// For each bit it issues load/add commands to the EC point datapath.
// It then doubles Q and asks the key-bit shifter for the next bit.
// All outputs are registered. Command pulses are one cycle wide, and
// they are raised on the transition into the state that owns them.

module scalar_mult_ctrl #(
  parameter int KEY_BITS = 32,
  parameter int CNT_W    = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             k_bit,
  input  logic             key_shift_done_to_control,
  output logic             key_shift_done_from_control,
  output logic             r_load,
  output logic             add_start,
  output logic             dbl_start,
  input  logic             op_done,
  output logic             busy,
  output logic             done,
  output logic             r_is_inf,
  output logic [CNT_W-1:0] bit_cnt
);

  // Sequencer states. LOAD and ADD each own one command pulse, and so
  // does DBL. OPW and DBLW park until the datapath reports completion.
  // SACK parks until the shifter acknowledges the index step.
  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ADD,
    S_OPW,
    S_CHK,
    S_DBL,
    S_DBLW,
    S_SREQ,
    S_SACK,
    S_FIN
  } state_t;

  // Index of the most significant key bit. No doubling is issued after it.
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(KEY_BITS - 1);

  state_t           state_q;
  logic             shift_req_q;
  logic             r_load_q;
  logic             add_start_q;
  logic             dbl_start_q;
  logic             busy_q;
  logic             done_q;
  logic             r_is_inf_q;
  logic [CNT_W-1:0] bit_cnt_q;

  // Single-block sequencer. Pulse registers default low every cycle, and
  // each one is set only on the transition into the state that owns it.
  // This keeps every pulse exactly one cycle wide, with at most one
  // command outstanding at a time.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      shift_req_q <= 1'b0;
      r_load_q    <= 1'b0;
      add_start_q <= 1'b0;
      dbl_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      r_is_inf_q  <= 1'b1;
      bit_cnt_q   <= '0;
    end else begin
      shift_req_q <= 1'b0;
      r_load_q    <= 1'b0;
      add_start_q <= 1'b0;
      dbl_start_q <= 1'b0;
      done_q      <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (i_start) begin
            state_q    <= S_FETCH;
            busy_q     <= 1'b1;
            r_is_inf_q <= 1'b1;
            bit_cnt_q  <= '0;
          end
        end

        // The first set bit loads R directly from Q. Later set bits add Q into R.
        S_FETCH: begin
          if (k_bit && r_is_inf_q) begin
            state_q  <= S_LOAD;
            r_load_q <= 1'b1;
          end else if (k_bit) begin
            state_q     <= S_ADD;
            add_start_q <= 1'b1;
          end else begin
            state_q <= S_CHK;
          end
        end

        S_LOAD: begin
          r_is_inf_q <= 1'b0;
          state_q    <= S_OPW;
        end

        S_ADD: begin
          state_q <= S_OPW;
        end

        S_OPW: begin
          if (op_done) begin
            state_q <= S_CHK;
          end
        end

        S_CHK: begin
          if (bit_cnt_q == LAST_BIT) begin
            state_q <= S_FIN;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q     <= S_DBL;
            dbl_start_q <= 1'b1;
          end
        end

        S_DBL: begin
          state_q <= S_DBLW;
        end

        S_DBLW: begin
          if (op_done) begin
            state_q     <= S_SREQ;
            shift_req_q <= 1'b1;
          end
        end

        S_SREQ: begin
          state_q <= S_SACK;
        end

        // The shifter has advanced its index once it acks.
        // FETCH therefore sees the new key bit.
        S_SACK: begin
          if (key_shift_done_to_control) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
            state_q   <= S_FETCH;
          end
        end

        S_FIN: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign key_shift_done_from_control = shift_req_q;
  assign r_load                      = r_load_q;
  assign add_start                   = add_start_q;
  assign dbl_start                   = dbl_start_q;
  assign busy                        = busy_q;
  assign done                        = done_q;
  assign r_is_inf                    = r_is_inf_q;
  assign bit_cnt                     = bit_cnt_q;

endmodule
